// File: rtl/freq_disp_pkg.sv
// Shared types and constants for the frequency display controller.
// Includes the per-digit add-3 correction used by the double-dabble engine.
package freq_disp_pkg;

  localparam int BCD_DIGITS  = 5;
  localparam int MAX_DISPLAY = 9999;
  localparam int CONV_STEPS  = 16;
  localparam int BCD_W       = 4 * BCD_DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_HOLD   = 2'd3
  } fsm_state_t;

  // A digit of 5 or more would exceed 9 after doubling, so pre-correct it.
  function automatic logic [3:0] add3_if_ge5(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble engine: one shift-add-3 step per clock,
// CONV_STEPS steps after start, result held in bcd until the next start.
module bin2bcd_seq
  import freq_disp_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [15:0]      bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  logic [15:0]      shift_q;
  logic [4:0]       step_q;
  logic [BCD_W-1:0] adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      adj[4*i +: 4] = add3_if_ge5(bcd[4*i +: 4]);
    end
  end

  // done is high in the cycle whose rising edge performs the final step.
  assign done = busy && (step_q == 5'(CONV_STEPS - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      step_q  <= '0;
      busy    <= 1'b0;
      bcd     <= '0;
    end else if (start && !busy) begin
      shift_q <= bin;
      step_q  <= '0;
      busy    <= 1'b1;
      bcd     <= '0;
    end else if (busy) begin
      bcd     <= {adj[BCD_W-2:0], shift_q[15]};
      shift_q <= {shift_q[14:0], 1'b0};
      step_q  <= step_q + 5'd1;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/freq_display_ctrl.sv
// Converts an accepted binary count to four BCD display digits with
// saturation at 9999, leading-zero blanking and a minimum display hold time.
module freq_display_ctrl
  import freq_disp_pkg::*;
#(
  parameter int W_IN = 16,
  parameter int HOLD = 262144
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [W_IN-1:0] value,
  input  logic            value_valid,
  output logic            value_ready,
  output logic [3:0]      digit0,
  output logic [3:0]      digit1,
  output logic [3:0]      digit2,
  output logic [3:0]      digit3,
  output logic [3:0]      blank,
  output logic            overflow,
  output logic            busy,
  output logic [1:0]      state_dbg
);

  localparam int HCW = $clog2(HOLD + 1);

  // Handshake: a value transfers on a rising edge where value_valid and
  // value_ready are both high; value_ready is high only in IDLE, and valid
  // seen in any other state is ignored rather than queued.

  fsm_state_t       state_q, state_d;
  logic [HCW-1:0]   hold_q;
  logic             hold_last;
  logic             accept;
  logic             eng_busy;
  logic             eng_done;
  logic [BCD_W-1:0] eng_bcd;

  logic [15:0]      c_digits;
  logic [3:0]       c_blank;
  logic             c_ovf;

  assign value_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign state_dbg   = state_q;
  assign accept      = value_valid && value_ready;
  assign hold_last   = (hold_q == HCW'(HOLD - 1));

  bin2bcd_seq u_bin2bcd (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (accept),
    .bin     (value),
    .busy    (eng_busy),
    .done    (eng_done),
    .bcd     (eng_bcd)
  );

  // Anything with a nonzero fifth digit is above 9999 and saturates.
  always_comb begin
    c_digits = eng_bcd[15:0];
    c_ovf    = 1'b0;
    c_blank  = 4'b0000;
    if (eng_bcd[BCD_W-1:16] != '0) begin
      c_digits = 16'h9999;
      c_ovf    = 1'b1;
    end
    c_blank[3] = (c_digits[15:12] == 4'd0);
    c_blank[2] = c_blank[3] && (c_digits[11:8] == 4'd0);
    c_blank[1] = c_blank[2] && (c_digits[7:4] == 4'd0);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_CONV;
      ST_CONV:   if (eng_done) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_HOLD;
      ST_HOLD:   if (hold_last) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_HOLD) begin
        hold_q <= hold_q + HCW'(1);
      end else begin
        hold_q <= '0;
      end
    end
  end

  // Display registers only change on the COMMIT edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      digit0   <= 4'd0;
      digit1   <= 4'd0;
      digit2   <= 4'd0;
      digit3   <= 4'd0;
      blank    <= 4'b1110;
      overflow <= 1'b0;
    end else if (state_q == ST_COMMIT) begin
      digit0   <= c_digits[3:0];
      digit1   <= c_digits[7:4];
      digit2   <= c_digits[11:8];
      digit3   <= c_digits[15:12];
      blank    <= c_blank;
      overflow <= c_ovf;
    end
  end

endmodule

// File: tb/tb_freq_display_ctrl.sv
// Directed bench for freq_display_ctrl with HOLD=8: expected displays are
// queued at each accepted handshake and compared on the commit edge.
module tb_freq_display_ctrl;
  import freq_disp_pkg::*;

  localparam int HOLD_TB = 8;
  localparam logic [20:0] RESET_VIEW = {1'b0, 4'b1110, 16'h0000};

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] value = '0;
  logic        value_valid = 1'b0;
  logic        value_ready;
  logic [3:0]  digit0, digit1, digit2, digit3;
  logic [3:0]  blank;
  logic        overflow;
  logic        busy;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [20:0] exp_q[$];
  logic [20:0] shown = RESET_VIEW;

  freq_display_ctrl #(.W_IN(16), .HOLD(HOLD_TB)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .value       (value),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .digit0      (digit0),
    .digit1      (digit1),
    .digit2      (digit2),
    .digit3      (digit3),
    .blank       (blank),
    .overflow    (overflow),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  always #5 clock = ~clock;

  function automatic logic [20:0] model(input int v);
    logic [3:0] d3, d2, d1, d0;
    logic b3, b2, b1;
    if (v > 9999) return {1'b1, 4'b0000, 16'h9999};
    d3 = 4'(v / 1000);
    d2 = 4'((v / 100) % 10);
    d1 = 4'((v / 10) % 10);
    d0 = 4'(v % 10);
    b3 = (d3 == 4'd0);
    b2 = b3 && (d2 == 4'd0);
    b1 = b2 && (d1 == 4'd0);
    return {1'b0, b3, b2, b1, 1'b0, d3, d2, d1, d0};
  endfunction

  function automatic logic [20:0] view();
    return {overflow, blank, digit3, digit2, digit1, digit0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns at #1 after the accepting edge; waits counts idle cycles first.
  task automatic handshake(input logic [15:0] v, input bit keep, output int waits);
    value = v;
    value_valid = 1'b1;
    waits = 0;
    while (!value_ready && waits < 100) begin
      @(posedge clock); #1;
      waits++;
    end
    if (!value_ready) begin
      check("handshake_timeout", 32'(value_ready), 32'd1);
      value_valid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    exp_q.push_back(model(int'(v)));
    if (!keep) value_valid = 1'b0;
    value = 16'($urandom_range(0, 65535));
  endtask

  task automatic finish_txn(input string tag, input bit hold_valid);
    logic [20:0] exp;
    check({tag, "_ready_low"}, 32'(value_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    repeat (16) begin
      if (hold_valid) value = 16'($urandom_range(0, 65535));
      @(posedge clock); #1;
    end
    check({tag, "_stable"}, 32'(view()), 32'(shown));
    @(posedge clock); #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_commit"}, 32'(view()), 32'(exp));
      shown = exp;
    end
    repeat (HOLD_TB - 1) begin
      if (hold_valid) value = 16'($urandom_range(0, 65535));
      @(posedge clock); #1;
    end
    check({tag, "_hold_ready_low"}, 32'(value_ready), 32'd0);
    @(posedge clock); #1;
    check({tag, "_ready_back"}, 32'(value_ready), 32'd1);
  endtask

  initial begin
    int w;
    logic [15:0] rv;

    repeat (3) @(posedge clock);
    #1;
    check("reset_view", 32'(view()), 32'(RESET_VIEW));
    check("reset_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    check("reset_ready", 32'(value_ready), 32'd1);

    handshake(16'd1234, 1'b0, w);
    check("first_hs_immediate", 32'(w), 32'd0);
    check("state_conv", 32'(state_dbg), 32'(ST_CONV));
    finish_txn("v1234", 1'b0);

    handshake(16'd7, 1'b0, w);      finish_txn("v7", 1'b0);
    handshake(16'd45, 1'b0, w);     finish_txn("v45", 1'b0);
    handshake(16'd0, 1'b0, w);      finish_txn("v0", 1'b0);
    handshake(16'd10000, 1'b0, w);  finish_txn("v10000", 1'b0);
    handshake(16'd65535, 1'b0, w);  finish_txn("v65535", 1'b0);
    handshake(16'd9999, 1'b0, w);   finish_txn("v9999", 1'b0);

    for (int i = 0; i < 3; i++) begin
      rv = 16'($urandom_range(0, 65535));
      handshake(rv, 1'b0, w);
      finish_txn("rand", 1'b0);
    end

    // valid held high through CONV/HOLD with churning value; must not accept.
    handshake(16'd500, 1'b1, w);
    finish_txn("b2b_first", 1'b1);
    handshake(16'd42, 1'b0, w);
    check("b2b_zero_idle", 32'(w), 32'd0);
    finish_txn("b2b_second", 1'b0);

    // Reset in the middle of conversion: nothing may be committed afterwards.
    handshake(16'd8765, 1'b0, w);
    repeat (8) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    shown = RESET_VIEW;
    check("abort_view", 32'(view()), 32'(RESET_VIEW));
    check("abort_busy", 32'(busy), 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    check("abort_no_commit", 32'(view()), 32'(RESET_VIEW));
    check("abort_ready", 32'(value_ready), 32'd1);

    handshake(16'd321, 1'b0, w);
    finish_txn("v321", 1'b0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
